serial_alu_ctrl: RTL and testbench

Bit-serial ALU sequencer. It runs one 1-bit ALU slice (the ALU_1bit function: Ainvert/Binvert/op[1:0], carry chain, less/set) over WIDTH cycles, LSB first, to perform a full-width AND/OR/NOR/ADD/SUB/SLT. The block latches operands, carries the ripple carry in a flip-flop between cycles, and assembles the result. It also produces zero and overflow flags. It sits between the HW datapath control and the shared slice, trading latency for area.

---
 rtl/serial_alu_ctrl.sv | 117 +++++++++++
 tb/tb_serial_alu_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU sequencer driving one 1-bit slice LSB-first over WIDTH cycles
module serial_alu_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALU_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
    logic [3:0]       op_q, op_d;
    logic             carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
    logic             a1, b1, set, cout, rbit, ovf, legal;
    logic [WIDTH-1:0] fin;
    always_comb begin
        legal = ALU_op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        a1    = op_q[3] ^ a_q[0];
        b1    = op_q[2] ^ b_q[0];
        set   = a1 ^ b1 ^ carry_q;
        cout  = (a1 & b1) | (a1 & carry_q) | (b1 & carry_q);
        rbit  = op_q[1] ? (op_q[0] ? 1'b0 : set) : (op_q[0] ? (a1 | b1) : (a1 & b1));
        // op[1] marks the arithmetic ops (ADD/SUB/SLT); logic ops never flag overflow
        ovf   = op_q[1] & (carry_q ^ cout);
        fin   = (op_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, set ^ ovf} : {rbit, sh_q[WIDTH-1:1]};
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        op_d     = op_q;
        carry_d  = carry_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                op_d    = ALU_op;
                carry_d = ALU_op[2];
                cnt_d   = '0;
                sh_d    = '0;
                state_d = legal ? RUN : DONE;
                if (!legal) begin
                    result_d = '0;
                    zero_d   = 1'b1;
                    ovf_d    = 1'b0;
                    ill_d    = 1'b1;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = cout;
                sh_d    = {rbit, sh_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    cnt_d    = '0;
                    state_d  = DONE;
                    result_d = fin;
                    zero_d   = (fin == '0);
                    ovf_d    = ovf;
                    ill_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
        end
    end
    assign ready    = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = ovf_q;
    assign illegal  = ill_q;
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: directed self-checking bench for serial_alu_ctrl (WIDTH=8)
module tb_serial_alu_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0] ALU_op = 4'b0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       ready, done, zero, overflow, illegal;
    logic [7:0] result;
    int         tests = 0, fails = 0;
    int         n, seen;

    serial_alu_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALU_op(ALU_op), .a(a), .b(b),
        .ready(ready), .done(done), .result(result), .zero(zero),
        .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n counts edges from the start-sampling edge up to the one that raises done
    task automatic run(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                       input bit inject, output int cyc);
        ALU_op = op; a = av; b = bv; start = 1'b1; cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            start = inject && (cyc == 4);
            if (start) begin a = 8'h11; b = 8'h22; ALU_op = 4'b0000; end
        end while (!done && cyc < 20);
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", {zero, overflow, illegal}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(4'b0010, 8'h7F, 8'h01, 0, n);
        chk("add_lat", n, 9);
        chk("add_ready_in_done", ready, 0);
        chk("add_result", result, 8'h80);
        chk("add_flags", {zero, overflow, illegal}, 3'b010);
        @(posedge clk); #1;
        chk("add_done_pulse", done, 0);
        chk("add_held", {ready, result}, {1'b1, 8'h80});

        run(4'b0110, 8'h05, 8'h05, 0, n);
        chk("sub_lat", n, 9);
        chk("sub_result", result, 8'h00);
        chk("sub_flags", {zero, overflow}, 2'b10);
        @(posedge clk); #1;

        run(4'b0111, 8'hFD, 8'h02, 0, n);
        chk("slt1_result", result, 8'h01);
        chk("slt1_ovf", overflow, 0);
        @(posedge clk); #1;

        run(4'b0111, 8'h80, 8'h01, 0, n);
        chk("slt2_result", result, 8'h01);
        chk("slt2_ovf", overflow, 1);
        @(posedge clk); #1;

        run(4'b0000, 8'hF0, 8'h3C, 0, n);
        chk("and_result", {result, overflow}, {8'h30, 1'b0});
        @(posedge clk); #1;
        run(4'b0001, 8'hF0, 8'h3C, 0, n);
        chk("or_result", {result, overflow}, {8'hFC, 1'b0});
        @(posedge clk); #1;
        run(4'b1100, 8'hF0, 8'h3C, 0, n);
        chk("nor_result", {result, overflow, zero}, {8'h03, 2'b00});
        @(posedge clk); #1;

        run(4'b0010, 8'h7F, 8'h01, 1, n);
        chk("ign_lat", n, 9);
        chk("ign_result", {result, overflow}, {8'h80, 1'b1});
        @(posedge clk); #1;
        chk("ign_no_restart", {ready, done}, 2'b10);

        ALU_op = 4'b0010; a = 8'h7F; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_keeps_outputs", result, 8'h80);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_run_done", done, 0);
        chk("rst_run_ready", ready, 1);
        chk("rst_run_out", {result, zero, overflow, illegal}, 12'h000);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin @(posedge clk); #1; seen |= int'(done); end
        chk("rst_run_no_done", seen, 0);

        run(4'b0101, 8'hAA, 8'h55, 0, n);
        chk("ill_lat", n, 1);
        chk("ill_out", {result, zero, overflow, illegal}, {8'h00, 3'b101});
        @(posedge clk); #1;
        chk("ill_idle", {ready, done, illegal}, 3'b101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
